// File: rtl/noc_pkg.sv
// Shared NoC constants: port indices, packet field positions and request width.
// Used by the input-port controller (ipctrl) and its route_compute helper.
package noc_pkg;

    localparam int PKT_W     = 64;
    localparam int REQ_W     = 5;
    localparam int HOP_W     = 4;
    localparam int DIR_X_BIT = 62;
    localparam int DIR_Y_BIT = 61;
    localparam int HOP_X_LSB = 52;
    localparam int HOP_Y_LSB = 48;

    typedef enum logic [2:0] {
        PORT_PE = 3'd0,
        PORT_S  = 3'd1,
        PORT_N  = 3'd2,
        PORT_E  = 3'd3,
        PORT_W  = 3'd4
    } port_e;

    function automatic logic [REQ_W-1:0] port_onehot(input port_e p);
        port_onehot = {{(REQ_W-1){1'b0}}, 1'b1} << p;
    endfunction

endpackage

// File: rtl/route_compute.sv
// Combinational XY router: one-hot request plus the packet as presented downstream.
// IPCTRL_HOP_DEC_EN: when defined, the hop field used for routing is decremented.
module route_compute
    import noc_pkg::*;
(
    input  logic [PKT_W-1:0] pkt_i,
    output logic [REQ_W-1:0] req_o,
    output logic [PKT_W-1:0] pkt_o
);

`ifdef IPCTRL_HOP_DEC_EN
    localparam logic [HOP_W-1:0] HOP_DEC = 4'd1;
`else
    localparam logic [HOP_W-1:0] HOP_DEC = 4'd0;
`endif

    logic [HOP_W-1:0] hop_x;
    logic [HOP_W-1:0] hop_y;

    assign hop_x = pkt_i[HOP_X_LSB +: HOP_W];
    assign hop_y = pkt_i[HOP_Y_LSB +: HOP_W];

    // X is exhausted before Y; a packet with both hops at zero has arrived.
    always_comb begin
        req_o = port_onehot(PORT_PE);
        pkt_o = pkt_i;
        if (hop_x != '0) begin
            req_o = pkt_i[DIR_X_BIT] ? port_onehot(PORT_W) : port_onehot(PORT_E);
            pkt_o[HOP_X_LSB +: HOP_W] = hop_x - HOP_DEC;
        end else if (hop_y != '0) begin
            req_o = pkt_i[DIR_Y_BIT] ? port_onehot(PORT_S) : port_onehot(PORT_N);
            pkt_o[HOP_Y_LSB +: HOP_W] = hop_y - HOP_DEC;
        end
    end

endmodule

// File: rtl/ipctrl.sv
// NoC input-port controller: even/odd ping-pong packet buffers selected by polarity.
// IPCTRL_HOP_DEC_EN (in route_compute) decrements the routing hop on presentation.
module ipctrl
    import noc_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             polarity,
    input  logic             send_in,
    input  logic [PKT_W-1:0] data_in,
    output logic             ready_in,
    output logic [REQ_W-1:0] req,
    output logic [PKT_W-1:0] data_out,
    input  logic             clear
);

    logic [PKT_W-1:0] buf_even_q, buf_even_d;
    logic [PKT_W-1:0] buf_odd_q,  buf_odd_d;
    logic             full_even_q, full_even_d;
    logic             full_odd_q,  full_odd_d;

    logic             wr_full;
    logic             rd_full;
    logic [PKT_W-1:0] rd_buf;
    logic             wr_en;
    logic             clr_en;
    logic [REQ_W-1:0] route_req;

    // polarity=0 writes even and reads odd; polarity=1 the reverse.
    assign wr_full = polarity ? full_odd_q : full_even_q;
    assign rd_full = polarity ? full_even_q : full_odd_q;
    assign rd_buf  = polarity ? buf_even_q : buf_odd_q;

    assign ready_in = ~wr_full;
    assign wr_en    = send_in & ~wr_full;
    assign clr_en   = clear & rd_full;

    always_comb begin
        buf_even_d  = buf_even_q;
        buf_odd_d   = buf_odd_q;
        full_even_d = full_even_q;
        full_odd_d  = full_odd_q;
        if (wr_en) begin
            if (polarity) begin
                buf_odd_d  = data_in;
                full_odd_d = 1'b1;
            end else begin
                buf_even_d  = data_in;
                full_even_d = 1'b1;
            end
        end
        // Write and clear always hit opposite buffers, so both may apply.
        if (clr_en) begin
            if (polarity) full_even_d = 1'b0;
            else          full_odd_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_even_q  <= '0;
            buf_odd_q   <= '0;
            full_even_q <= 1'b0;
            full_odd_q  <= 1'b0;
        end else begin
            buf_even_q  <= buf_even_d;
            buf_odd_q   <= buf_odd_d;
            full_even_q <= full_even_d;
            full_odd_q  <= full_odd_d;
        end
    end

    route_compute u_route (
        .pkt_i (rd_buf),
        .req_o (route_req),
        .pkt_o (data_out)
    );

    assign req = rd_full ? route_req : '0;

endmodule

// File: tb/tb_ipctrl.sv
// Self-checking bench for ipctrl: directed scenarios plus random traffic vs a buffer model.
module tb_ipctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        polarity = 1'b0;
    logic        send_in = 1'b0;
    logic [63:0] data_in = '0;
    logic        clear = 1'b0;
    logic        ready_in;
    logic [4:0]  req;
    logic [63:0] data_out;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Model: index 0 = buf_even, 1 = buf_odd.
    logic [63:0] m_buf [2];
    bit          m_full [2];

    ipctrl dut (
        .clk      (clk),
        .reset    (reset),
        .polarity (polarity),
        .send_in  (send_in),
        .data_in  (data_in),
        .ready_in (ready_in),
        .req      (req),
        .data_out (data_out),
        .clear    (clear)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mk_pkt(input bit dx, input bit dy,
                                           input int hx, input int hy);
        logic [63:0] p;
        p = {$urandom, $urandom};
        p[62] = dx;
        p[61] = dy;
        p[55:52] = 4'(hx);
        p[51:48] = 4'(hy);
        return p;
    endfunction

    function automatic logic [4:0] ref_route(input logic [63:0] p);
        if (p[55:52] != 0) return p[62] ? 5'b10000 : 5'b01000;
        if (p[51:48] != 0) return p[61] ? 5'b00010 : 5'b00100;
        return 5'b00001;
    endfunction

    function automatic logic [63:0] ref_data(input logic [63:0] p);
`ifdef IPCTRL_HOP_DEC_EN
        if (p[55:52] != 0) return p - (64'd1 << 52);
        if (p[51:48] != 0) return p - (64'd1 << 48);
`endif
        return p;
    endfunction

    function automatic logic exp_ready();
        return !m_full[polarity];
    endfunction

    function automatic logic [4:0] exp_req();
        return m_full[!polarity] ? ref_route(m_buf[!polarity]) : 5'b0;
    endfunction

    function automatic bit rd_full();
        return m_full[!polarity];
    endfunction

    function automatic logic [63:0] exp_data();
        return ref_data(m_buf[!polarity]);
    endfunction

    task automatic model_reset();
        m_buf[0] = '0; m_buf[1] = '0;
        m_full[0] = 0; m_full[1] = 0;
    endtask

    task automatic drive(input logic pol, input logic snd, input logic [63:0] d, input logic clr);
        @(negedge clk);
        polarity = pol; send_in = snd; data_in = d; clear = clr;
        #1;
    endtask

    // Advance one rising edge and apply the same edge to the model.
    task automatic tick();
        bit w_ok, c_ok;
        int wi, ri;
        wi = polarity ? 1 : 0;
        ri = 1 - wi;
        w_ok = send_in && !m_full[wi];
        c_ok = clear && m_full[ri];
        @(posedge clk);
        if (w_ok) begin m_buf[wi] = data_in; m_full[wi] = 1; end
        if (c_ok) m_full[ri] = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        vec_cnt++; if (ready_in !== 1'b1) begin err_cnt++; $display("FAIL reset_ready got %b want 1", ready_in); end
        vec_cnt++; if (req !== 5'b0) begin err_cnt++; $display("FAIL reset_req got %b want 00000", req); end
        vec_cnt++; if (data_out !== 64'd0) begin err_cnt++; $display("FAIL reset_data got %h want 0", data_out); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic_route();
        logic [63:0] p;
        p = mk_pkt(0, $urandom_range(0, 1), 2, $urandom_range(0, 15));
        drive(0, 1, p, 0);
        vec_cnt++; if (ready_in !== 1'b1) begin err_cnt++; $display("FAIL basic_ready got %b want 1", ready_in); end
        tick();
        drive(1, 0, '0, 0);
        vec_cnt++; if (req !== 5'b01000) begin err_cnt++; $display("FAIL basic_req got %b want 01000", req); end
`ifdef IPCTRL_HOP_DEC_EN
        vec_cnt++; if (data_out[55:52] !== 4'd1) begin err_cnt++; $display("FAIL basic_hopx got %0d want 1", data_out[55:52]); end
`else
        vec_cnt++; if (data_out[55:52] !== 4'd2) begin err_cnt++; $display("FAIL basic_hopx got %0d want 2", data_out[55:52]); end
`endif
        vec_cnt++; if (data_out !== ref_data(p)) begin err_cnt++; $display("FAIL basic_data got %h want %h", data_out, ref_data(p)); end
        // Writing the odd buffer is still open while even is being read.
        vec_cnt++; if (ready_in !== 1'b1) begin err_cnt++; $display("FAIL basic_odd_ready got %b want 1", ready_in); end
        clear = 1'b1;
        tick();
        drive(1, 0, '0, 0);
        vec_cnt++; if (req !== 5'b0) begin err_cnt++; $display("FAIL basic_cleared_req got %b want 00000", req); end
    endtask

    task automatic test_yx_pe_routes();
        logic [63:0] p;
        p = mk_pkt($urandom_range(0, 1), 1, 0, 3);
        drive(0, 1, p, 0); tick();
        drive(1, 0, '0, 0);
        vec_cnt++; if (req !== 5'b00010) begin err_cnt++; $display("FAIL route_s got %b want 00010", req); end
        vec_cnt++; if (data_out !== ref_data(p)) begin err_cnt++; $display("FAIL route_s_data got %h want %h", data_out, ref_data(p)); end
        clear = 1'b1; tick();
        p = mk_pkt($urandom_range(0, 1), $urandom_range(0, 1), 0, 0);
        drive(1, 1, p, 0); tick();
        drive(0, 0, '0, 0);
        vec_cnt++; if (req !== 5'b00001) begin err_cnt++; $display("FAIL route_pe got %b want 00001", req); end
        vec_cnt++; if (data_out !== p) begin err_cnt++; $display("FAIL route_pe_data got %h want %h", data_out, p); end
        clear = 1'b1; tick();
    endtask

    task automatic test_full_block();
        logic [63:0] p_old, p_new;
        p_old = mk_pkt(1, 0, 5, 1);
        p_new = mk_pkt(0, 1, 0, 7);
        drive(0, 1, p_old, 0); tick();
        drive(0, 1, p_new, 0);
        vec_cnt++; if (ready_in !== 1'b0) begin err_cnt++; $display("FAIL block_ready got %b want 0", ready_in); end
        tick();
        drive(1, 0, '0, 0);
        vec_cnt++; if (req !== 5'b10000) begin err_cnt++; $display("FAIL block_req got %b want 10000", req); end
        vec_cnt++; if (data_out !== ref_data(p_old)) begin err_cnt++; $display("FAIL block_data got %h want %h", data_out, ref_data(p_old)); end
        // Leave buf_even full for the write-plus-clear scenario.
    endtask

    task automatic test_write_and_clear();
        logic [63:0] p;
        p = mk_pkt(0, 0, 0, 4);
        drive(1, 1, p, 1);
        tick();
        drive(1, 0, '0, 0);
        vec_cnt++; if (req !== 5'b0) begin err_cnt++; $display("FAIL wc_even_req got %b want 00000", req); end
        vec_cnt++; if (ready_in !== 1'b0) begin err_cnt++; $display("FAIL wc_odd_ready got %b want 0", ready_in); end
        drive(0, 0, '0, 0);
        vec_cnt++; if (req !== 5'b00100) begin err_cnt++; $display("FAIL wc_odd_req got %b want 00100", req); end
        vec_cnt++; if (data_out !== ref_data(p)) begin err_cnt++; $display("FAIL wc_odd_data got %h want %h", data_out, ref_data(p)); end
        vec_cnt++; if (ready_in !== 1'b1) begin err_cnt++; $display("FAIL wc_even_ready got %b want 1", ready_in); end
        clear = 1'b1; tick();
    endtask

    task automatic test_clear_empty();
        drive(1, 0, '0, 1); tick();
        drive(1, 0, '0, 1);
        vec_cnt++; if (req !== 5'b0) begin err_cnt++; $display("FAIL clr_empty_req got %b want 00000", req); end
        vec_cnt++; if (ready_in !== 1'b1) begin err_cnt++; $display("FAIL clr_empty_ready got %b want 1", ready_in); end
        tick();
        drive(0, 0, '0, 1);
        vec_cnt++; if (req !== 5'b0) begin err_cnt++; $display("FAIL clr_empty_req2 got %b want 00000", req); end
        tick();
    endtask

    task automatic test_async_reset();
        drive(0, 1, mk_pkt(1, 1, 3, 2), 0); tick();
        drive(1, 1, mk_pkt(0, 1, 0, 2), 0); tick();
        drive(1, 0, '0, 0);
        vec_cnt++; if (req !== exp_req()) begin err_cnt++; $display("FAIL arst_pre_req got %b want %b", req, exp_req()); end
        #2 reset = 1'b1;
        #1;
        vec_cnt++; if (req !== 5'b0) begin err_cnt++; $display("FAIL arst_req got %b want 00000", req); end
        vec_cnt++; if (data_out !== 64'd0) begin err_cnt++; $display("FAIL arst_data got %h want 0", data_out); end
        vec_cnt++; if (ready_in !== 1'b1) begin err_cnt++; $display("FAIL arst_ready got %b want 1", ready_in); end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, '0, 0);
        vec_cnt++; if (req !== 5'b0 || ready_in !== 1'b1) begin err_cnt++; $display("FAIL arst_after got req=%b ready=%b want 00000/1", req, ready_in); end
        tick();
    endtask

    task automatic test_random();
        logic [63:0] p;
        for (int i = 0; i < 400; i++) begin
            p = mk_pkt($urandom_range(0, 1), $urandom_range(0, 1),
                       ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 15),
                       ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 15));
            drive($urandom_range(0, 1), $urandom_range(0, 1), p, ($urandom_range(0, 3) == 0));
            vec_cnt++; if (ready_in !== exp_ready()) begin err_cnt++; $display("FAIL rnd_ready[%0d] got %b want %b", i, ready_in, exp_ready()); end
            vec_cnt++; if (req !== exp_req()) begin err_cnt++; $display("FAIL rnd_req[%0d] got %b want %b", i, req, exp_req()); end
            vec_cnt++; if ($countones(req) > 1) begin err_cnt++; $display("FAIL rnd_onehot[%0d] got %b want <=1 bit", i, req); end
            if (rd_full()) begin
                vec_cnt++; if (data_out !== exp_data()) begin err_cnt++; $display("FAIL rnd_data[%0d] got %h want %h", i, data_out, exp_data()); end
            end
            tick();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_route();
        test_yx_pe_routes();
        test_full_block();
        test_write_and_clear();
        test_clear_empty();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/ipctrl.md
IPCTRL -- requirements
Module: ipctrl

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: polarity  in  1  0 = even cycle, 1 = odd cycle.
REQ-004 SHALL have ports: send_in  in  1  upstream link asserts valid data_in.
REQ-005 SHALL have ports: data_in  in  64  upstream packet.
REQ-006 SHALL have ports: ready_in  out  1  this port can accept a packet this cycle.
REQ-007 SHALL have ports: req  out  5  one-hot request to output controllers, bit order {W,E,N,S,PE} = [4:0].
REQ-008 SHALL have ports: data_out  out  64  packet presented to output controllers.
REQ-009 SHALL have ports: clear  in  1  granted output controller has taken the presented packet.

Function
REQ-010 SHALL hold two single-packet buffers, buf_even and buf_odd, each with a full flag.
REQ-011 SHALL define the write buffer as buf_even when polarity=0 and buf_odd when polarity=1; the read buffer is the other one.
REQ-012 SHALL drive ready_in = ~full[write buffer], combinationally from registered state and polarity.
REQ-013 SHALL, on an edge with send_in=1 and ready_in=1, load data_in into the write buffer and set its full flag; latency to presentation is 1 cycle after polarity toggles.
REQ-014 SHALL ignore send_in when ready_in=0: buffer contents and flags are unchanged and nothing is dropped silently into another buffer.
REQ-015 SHALL drive data_out from the read buffer and req from the route of that buffer when its full flag=1; req=5'b00000 when the read buffer is empty.
REQ-016 SHALL compute the route from packet fields [62] dir_x (0=E,1=W), [61] dir_y (0=N,1=S), [55:52] hop_x, [51:48] hop_y using XY order: hop_x!=0 -> E/W; else hop_y!=0 -> N/S; else PE.
REQ-017 SHALL, on an edge with clear=1, reset the read buffer's full flag; clear with an empty read buffer is ignored.
REQ-018 SHALL allow a write and a clear in the same cycle, since they target different buffers, with both taking effect.
REQ-019 SHALL keep req one-hot or zero at all times; more than one set bit is a design error.

Reset
REQ-020 SHALL, on reset=1 at any time including mid-packet, clear both full flags and both buffers to 0; req=0, data_out=0, ready_in=1.
REQ-021 SHALL resume normal operation on the first rising edge after reset deasserts, with no pending packet retained.

Configuration
REQ-022 SHALL, when IPCTRL_HOP_DEC_EN is defined, present data_out with the hop field used for routing (hop_x, or else hop_y) decremented by 1; the PE route leaves the packet unchanged.
REQ-023 SHALL, when IPCTRL_HOP_DEC_EN is undefined, present data_out bit-identical to the stored packet.

Structure
REQ-024 SHALL take port index constants (PE=0,S=1,N=2,E=3,W=4), packet field positions and the 5-bit request width from shared package noc_pkg.
REQ-025 SHALL place XY route and hop decrement in a combinational sub-module route_compute, used once on the read buffer.

Verification
REQ-026 SHALL cover: reset, then polarity=0, send_in=1, data_in hop_x=2 dir_x=0 -> ready_in=1, full_even set; next cycle with polarity=1 -> req=5'b01000, data_out hop_x=1 when the macro is defined.
REQ-027 SHALL cover: stored packet with hop_x=0, hop_y=3, dir_y=1 -> req=5'b00010; packet with hop_x=0, hop_y=0 -> req=5'b00001 and data_out unchanged.
REQ-028 SHALL cover: buf_even full, polarity=0, send_in=1 with new data -> ready_in=0 and buf_even retains the old packet.
REQ-029 SHALL cover: polarity=1 with read buffer buf_even full, clear=1 and send_in=1 on the same edge -> buf_even empties, buf_odd loads, req=0 on the next odd cycle unless buf_odd is read.
REQ-030 SHALL cover: reset asserted asynchronously between edges while both buffers are full -> req=0, data_out=0, ready_in=1 immediately, without waiting for a clk edge.
REQ-031 SHALL cover: clear=1 with the read buffer empty -> no state change and req stays 0.
